// File: rtl/bht_update_queue.sv
// In-order FIFO that buffers resolved conditional-branch outcomes for the BHT update port.
// Execute is never stalled: a push into a full queue without a same-cycle pop is dropped and counted.
module bht_update_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DROP_CNT_W = 8,
    parameter int unsigned VLEN       = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         debug_mode_i,
    input  logic                         resolve_valid_i,
    input  logic                         resolve_is_branch_i,
    input  logic [VLEN-1:0]              resolve_pc_i,
    input  logic                         resolve_taken_i,
    output logic                         bht_update_valid_o,
    output logic [VLEN-1:0]              bht_update_pc_o,
    output logic                         bht_update_taken_o,
    input  logic                         bht_update_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [DROP_CNT_W-1:0]        drop_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [VLEN-1:0]       pc_q    [DEPTH];
    logic                  taken_q [DEPTH];
    logic [PTR_W-1:0]      rptr_q;
    logic [PTR_W-1:0]      wptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    logic push;
    logic pop;
    logic full;
    logic accept;
    logic drop;

    assign push   = resolve_valid_i & resolve_is_branch_i & ~debug_mode_i & ~flush_i;
    assign pop    = bht_update_valid_o & bht_update_ready_i;
    assign full   = (count_q == CNT_W'(DEPTH));
    // A full queue still takes a push when the head leaves in the same cycle.
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]    <= '0;
                taken_q[i] <= 1'b0;
            end
        end else if (flush_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (accept) begin
                pc_q[wptr_q]    <= resolve_pc_i;
                taken_q[wptr_q] <= resolve_taken_i;
                wptr_q          <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
            end
        end
    end

    assign bht_update_valid_o = (count_q != '0);
    assign bht_update_pc_o    = pc_q[rptr_q];
    assign bht_update_taken_o = taken_q[rptr_q];
    assign count_o            = count_q;
    assign drop_cnt_o         = drop_cnt_q;

endmodule
